// File: rtl/lwe_encrypt_stream_if.sv
// Handshake bundle for the streaming LWE encryptor:
// start request, public-key beat stream and ciphertext element stream.
interface lwe_encrypt_stream_if #(
    parameter int PT_WIDTH  = 6,
    parameter int CT_WIDTH  = 10,
    parameter int DIMENSION = 1,
    parameter int BIG_N     = 30,
    parameter int LANES     = 4
);
    localparam int RW = (DIMENSION > 0) ? $clog2(DIMENSION + 1) : 1;

    logic                      start_valid;
    logic                      start_ready;
    logic [PT_WIDTH-1:0]       plaintext;
    logic [BIG_N-1:0]          noise_select;
    logic                      pk_valid;
    logic                      pk_ready;
    logic [LANES*CT_WIDTH-1:0] pk_data;
    logic                      ct_valid;
    logic                      ct_ready;
    logic [CT_WIDTH-1:0]       ct_data;
    logic [RW-1:0]             ct_row;
    logic                      ct_last;
    logic                      done;

    modport master (
        output start_valid, plaintext, noise_select,
        output pk_valid, pk_data, ct_ready,
        input  start_ready, pk_ready, ct_valid,
        input  ct_data, ct_row, ct_last, done
    );

    modport slave (
        input  start_valid, plaintext, noise_select,
        input  pk_valid, pk_data, ct_ready,
        output start_ready, pk_ready, ct_valid,
        output ct_data, ct_row, ct_last, done
    );
endinterface

// File: rtl/lwe_encrypt_stream.sv
// Streaming LWE encryption: accumulates selected public-key columns per row
// and emits DIMENSION+1 ciphertext elements, plaintext*DELTA on the last one.
module lwe_encrypt_stream #(
    parameter int PT_WIDTH  = 6,
    parameter int CT_WIDTH  = 10,
    parameter int DIMENSION = 1,
    parameter int BIG_N     = 30,
    parameter int LANES     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lwe_encrypt_stream_if.slave   bus
);
    localparam int BEATS = (BIG_N + LANES - 1) / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW    = (DIMENSION > 0) ? $clog2(DIMENSION + 1) : 1;
    localparam int PADW  = BEATS * LANES;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT
    } state_t;

    state_t                     state_q;
    logic [PT_WIDTH-1:0]        pt_q;
    logic [BIG_N-1:0]           sel_q;
    logic [CT_WIDTH-1:0]        acc_q;
    logic [RW-1:0]              row_q;
    logic [BW-1:0]              beat_q;
    logic [CT_WIDTH-1:0]        ct_data_q;
    logic [RW-1:0]              ct_row_q;
    logic                       ct_valid_q;
    logic                       ct_last_q;
    logic                       done_q;
    logic                       pk_ready_q;
    logic                       start_ready_q;

    logic [BEATS-1:0][LANES-1:0] sel_pad;
    logic [LANES-1:0]            sel_beat;
    logic [CT_WIDTH-1:0]         part_d;
    logic [CT_WIDTH-1:0]         sum_d;
    logic [CT_WIDTH-1:0]         pt_term;
    logic [CT_WIDTH-1:0]         ct_data_d;
    logic                        last_beat;
    logic                        last_row;

    // Zero-padded selector: lanes past BIG_N in the final beat never count.
    always_comb begin
        sel_pad  = PADW'(sel_q);
        sel_beat = sel_pad[beat_q];
    end

    // Sum of the selected lanes of the current beat, mod 2^CT_WIDTH.
    always_comb begin
        part_d = '0;
        for (int l = 0; l < LANES; l++) begin
            if (sel_beat[l]) begin
                part_d = part_d + bus.pk_data[l*CT_WIDTH +: CT_WIDTH];
            end
        end
    end

    // Row total and final element value including the scaled plaintext.
    always_comb begin
        last_beat = (beat_q == BW'(BEATS - 1));
        last_row  = (row_q == RW'(DIMENSION));
        pt_term   = {pt_q, {(CT_WIDTH - PT_WIDTH){1'b0}}};
        sum_d     = acc_q + part_d;
        ct_data_d = last_row ? (sum_d + pt_term) : sum_d;
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pt_q          <= '0;
            sel_q         <= '0;
            acc_q         <= '0;
            row_q         <= '0;
            beat_q        <= '0;
            ct_data_q     <= '0;
            ct_row_q      <= '0;
            ct_valid_q    <= 1'b0;
            ct_last_q     <= 1'b0;
            done_q        <= 1'b0;
            pk_ready_q    <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        pt_q          <= bus.plaintext;
                        sel_q         <= bus.noise_select;
                        acc_q         <= '0;
                        row_q         <= '0;
                        beat_q        <= '0;
                        start_ready_q <= 1'b0;
                        pk_ready_q    <= 1'b1;
                        state_q       <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.pk_valid) begin
                        if (last_beat) begin
                            ct_data_q  <= ct_data_d;
                            ct_row_q   <= row_q;
                            ct_last_q  <= last_row;
                            ct_valid_q <= 1'b1;
                            pk_ready_q <= 1'b0;
                            state_q    <= EMIT;
                        end else begin
                            acc_q  <= sum_d;
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.ct_ready) begin
                        ct_valid_q <= 1'b0;
                        ct_last_q  <= 1'b0;
                        if (last_row) begin
                            done_q        <= 1'b1;
                            start_ready_q <= 1'b1;
                            state_q       <= IDLE;
                        end else begin
                            row_q      <= row_q + 1'b1;
                            beat_q     <= '0;
                            acc_q      <= '0;
                            pk_ready_q <= 1'b1;
                            state_q    <= ACCUM;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.pk_ready    = pk_ready_q;
    assign bus.ct_valid    = ct_valid_q;
    assign bus.ct_data     = ct_data_q;
    assign bus.ct_row      = ct_row_q;
    assign bus.ct_last     = ct_last_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_lwe_encrypt_stream.sv
// Directed bench for lwe_encrypt_stream: small config (BIG_N=5, LANES=2)
// plus a default-parameter instance for the all-zero selector case.
module tb_lwe_encrypt_stream;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    lwe_encrypt_stream_if #(
        .PT_WIDTH(6), .CT_WIDTH(10), .DIMENSION(1), .BIG_N(5), .LANES(2)
    ) a ();

    lwe_encrypt_stream_if b ();

    lwe_encrypt_stream #(
        .PT_WIDTH(6), .CT_WIDTH(10), .DIMENSION(1), .BIG_N(5), .LANES(2)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a.slave)
    );

    lwe_encrypt_stream dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_a(input logic [5:0] pt, input logic [4:0] sel);
        @(negedge clk);
        chk("start_ready_idle", a.start_ready, 1);
        a.start_valid  = 1'b1;
        a.plaintext    = pt;
        a.noise_select = sel;
        @(posedge clk);
        #1;
        a.start_valid = 1'b0;
        chk("start_ready_busy", a.start_ready, 0);
    endtask

    task automatic beat_a(input logic [9:0] l0, input logic [9:0] l1,
                          input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        a.pk_valid = 1'b1;
        a.pk_data  = {l1, l0};
        n = 0;
        while (a.pk_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("pk_ready_wait", (n < 40), 1);
        @(posedge clk);
        #1;
        a.pk_valid = 1'b0;
        a.pk_data  = '1;
    endtask

    task automatic ct_a(input logic [9:0] d, input logic r,
                        input logic last, input int hold);
        int n;
        @(negedge clk);
        n = 0;
        while (a.ct_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ct_latency", n, 0);
        chk("ct_data", a.ct_data, d);
        chk("ct_row", a.ct_row, r);
        chk("ct_last", a.ct_last, last);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", a.ct_valid, 1);
            chk("hold_data", a.ct_data, d);
            chk("hold_pk_ready", a.pk_ready, 0);
        end
        a.ct_ready = 1'b1;
        @(posedge clk);
        #1;
        a.ct_ready = 1'b0;
        @(negedge clk);
        chk("done_pulse", a.done, last);
        if (last) begin
            chk("start_ready_after", a.start_ready, 1);
            @(negedge clk);
            chk("done_single", a.done, 0);
        end
    endtask

    task automatic run_basic(input int gap, input int hold);
        start_a(6'd5, 5'b10110);
        beat_a(10'd100, 10'd200, gap);
        beat_a(10'd300, 10'd400, gap);
        beat_a(10'd500, 10'd999, gap);
        ct_a(10'd1000, 1'b0, 1'b0, hold);
        beat_a(10'd10, 10'd20, gap);
        beat_a(10'd30, 10'd40, gap);
        beat_a(10'd50, 10'd999, gap);
        ct_a(10'd180, 1'b1, 1'b1, 0);
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a.start_valid = 1'b0; a.plaintext = '0; a.noise_select = '0;
        a.pk_valid = 1'b0; a.pk_data = '0; a.ct_ready = 1'b0;
        b.start_valid = 1'b0; b.plaintext = '0; b.noise_select = '0;
        b.pk_valid = 1'b0; b.pk_data = '0; b.ct_ready = 1'b0;
        #12;
        chk("rst_start_ready", a.start_ready, 1);
        chk("rst_pk_ready", a.pk_ready, 0);
        chk("rst_ct_valid", a.ct_valid, 0);
        chk("rst_ct_data", a.ct_data, 0);
        chk("rst_done", a.done, 0);
        rst_n = 1'b1;

        // basic
        run_basic(0, 0);

        // wrap-around
        start_a(6'd63, 5'b11111);
        beat_a(10'd1000, 10'd1000, 0);
        beat_a(10'd1000, 10'd1000, 0);
        beat_a(10'd1000, 10'd1000, 0);
        ct_a(10'd904, 1'b0, 1'b0, 0);
        beat_a(10'd0, 10'd0, 0);
        beat_a(10'd0, 10'd0, 0);
        beat_a(10'd0, 10'd0, 0);
        ct_a(10'd1008, 1'b1, 1'b1, 0);

        // backpressure
        run_basic(0, 5);

        // handshake gaps with a stray start while busy
        start_a(6'd5, 5'b10110);
        beat_a(10'd100, 10'd200, $urandom_range(1, 3));
        @(negedge clk);
        chk("stray_start_ready", a.start_ready, 0);
        a.start_valid  = 1'b1;
        a.plaintext    = 6'd7;
        a.noise_select = 5'b11111;
        @(posedge clk);
        #1;
        a.start_valid = 1'b0;
        chk("stray_still_busy", a.start_ready, 0);
        beat_a(10'd300, 10'd400, $urandom_range(0, 3));
        beat_a(10'd500, 10'd999, $urandom_range(0, 3));
        ct_a(10'd1000, 1'b0, 1'b0, 0);
        beat_a(10'd10, 10'd20, $urandom_range(0, 3));
        beat_a(10'd30, 10'd40, $urandom_range(0, 3));
        beat_a(10'd50, 10'd999, $urandom_range(0, 3));
        ct_a(10'd180, 1'b1, 1'b1, 0);

        // reset mid-operation
        start_a(6'd5, 5'b10110);
        beat_a(10'd100, 10'd200, 0);
        beat_a(10'd300, 10'd400, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start_ready", a.start_ready, 1);
        chk("mid_rst_pk_ready", a.pk_ready, 0);
        chk("mid_rst_ct_valid", a.ct_valid, 0);
        chk("mid_rst_ct_data", a.ct_data, 0);
        chk("mid_rst_ct_row", a.ct_row, 0);
        chk("mid_rst_ct_last", a.ct_last, 0);
        chk("mid_rst_done", a.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_basic(0, 0);

        // default parameters, empty selector
        @(negedge clk);
        chk("b_start_ready", b.start_ready, 1);
        b.start_valid  = 1'b1;
        b.plaintext    = 6'd5;
        b.noise_select = '0;
        @(posedge clk);
        #1;
        b.start_valid = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                b.pk_valid = 1'b1;
                b.pk_data  = {$urandom, $urandom};
                n = 0;
                while (b.pk_ready !== 1'b1 && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                chk("b_pk_wait", (n < 40), 1);
                @(posedge clk);
                #1;
                b.pk_valid = 1'b0;
            end
            @(negedge clk);
            chk("b_ct_valid", b.ct_valid, 1);
            chk("b_ct_data", b.ct_data, (r == 1) ? 80 : 0);
            chk("b_ct_row", b.ct_row, r);
            chk("b_ct_last", b.ct_last, (r == 1));
            b.ct_ready = 1'b1;
            @(posedge clk);
            #1;
            b.ct_ready = 1'b0;
            @(negedge clk);
            chk("b_done", b.done, (r == 1));
        end
        @(negedge clk);
        chk("b_done_single", b.done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lwe_encrypt_stream.md
Name: lwe_encrypt_stream

Overview:
- Streaming, parametrised successor to the single-row LWE encrypt block.
- Computes all DIMENSION+1 ciphertext elements of one LWE encryption:
  - The public-key matrix (DIMENSION+1 rows x BIG_N columns) arrives row-major over a valid/ready stream, LANES entries per beat.
  - Entries whose noise_select bit is set are accumulated mod 2^CT_WIDTH.
  - The scaled plaintext is added into the last row only.
- Sits between the public-key memory streamer and the ciphertext output FIFO.

Parameters:
- PT_WIDTH, 6: plaintext width; plaintext modulus is 2^PT_WIDTH.
- CT_WIDTH, 10: ciphertext width; ciphertext modulus is 2^CT_WIDTH. Must satisfy CT_WIDTH > PT_WIDTH.
- DIMENSION, 1: LWE dimension; DIMENSION+1 ciphertext elements per encryption.
- BIG_N, 30: public-key samples per row; width of noise_select.
- LANES, 4: public-key entries per input beat, 1..BIG_N.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request a new encryption.
- start_ready  out  1  high in IDLE only.
- plaintext  in  PT_WIDTH  latched on start fire.
- noise_select  in  BIG_N  subset selector; latched on start fire.
- pk_valid  in  1  public-key beat valid.
- pk_ready  out  1  high in ACCUM only.
- pk_data  in  LANES*CT_WIDTH  lane l = bits [l*CT_WIDTH +: CT_WIDTH] = column beat*LANES+l.
- ct_valid  out  1  ciphertext element valid.
- ct_ready  in  1  downstream accepts element.
- ct_data  out  CT_WIDTH  ciphertext element.
- ct_row  out  max(1,$clog2(DIMENSION+1))  row index of ct_data.
- ct_last  out  1  high with ct_valid when ct_row==DIMENSION.
- done  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Derived values:
  - BEATS = ceil(BIG_N/LANES) beats per row.
  - DELTA = 2^(CT_WIDTH-PT_WIDTH).
- States: IDLE, ACCUM, EMIT.
- Reset (async, rst_n low):
  - State = IDLE.
  - Accumulator, row, beat, ct_data, ct_row = 0.
  - ct_valid, ct_last, done, pk_ready = 0; start_ready = 1.
  - In-flight work is discarded; resumes cleanly from IDLE after release.
- IDLE:
  - On start_valid & start_ready: latch plaintext and noise_select; row=0, beat=0, acc=0; go to ACCUM.
- ACCUM, on pk_valid & pk_ready:
  - acc += sum of lane l where idx = beat*LANES+l, idx < BIG_N and noise_select[idx]=1.
  - All additions mod 2^CT_WIDTH (truncate).
  - Lanes with idx >= BIG_N in the final beat are ignored regardless of their data.
  - Not last beat: beat++.
  - Last beat (beat==BEATS-1): ct_data = acc + beat partial, plus plaintext*DELTA if row==DIMENSION, all mod 2^CT_WIDTH. Set ct_row=row; go to EMIT.
  - Latency: ct_valid rises the cycle after the final beat fire.
- EMIT:
  - ct_valid=1; ct_data, ct_row, ct_last held stable until ct_ready.
  - pk_ready=0 (backpressure).
  - On ct_ready, if row<DIMENSION: row++, beat=0, acc=0, go to ACCUM.
  - On ct_ready, if row==DIMENSION: go to IDLE, pulse done for one cycle.
- Handshake and boundary rules:
  - start_valid is ignored outside IDLE.
  - pk_valid is ignored outside ACCUM.
  - ct_valid never drops without ct_ready.
  - Back-to-back: start may fire the cycle after done, i.e. the first IDLE cycle.
  - noise_select all-zero: last-row element = plaintext*DELTA; other rows = 0.
  - LANES==BIG_N: one beat per row.
  - DIMENSION==0: a single element, which carries the plaintext.

Test Plan (CT_WIDTH=10, PT_WIDTH=6, DIMENSION=1, BIG_N=5, LANES=2, DELTA=16):
- Basic:
  - Stimulus: plaintext=5, noise_select=5'b10110; row0 = 100,200,300,400,500; row1 = 10,20,30,40,50 (3 beats/row, last beat lane1 = 999 junk).
  - Required: ct row0 = 1000 (ct_last=0); ct row1 = 20+30+50+80 = 180 (ct_last=1); done pulses once.
- Wrap-around:
  - Stimulus: plaintext=63, select all; row0 all 1000; row1 all 0.
  - Required: row0 = 5000 mod 1024 = 904; row1 = 1008.
- Backpressure:
  - Stimulus: basic case with ct_ready held low 5 cycles in EMIT.
  - Required: ct_data stays 1000, pk_ready=0 throughout; results unchanged.
- Handshake gaps:
  - Stimulus: random pk_valid gaps; start_valid pulsed while in ACCUM.
  - Required: identical results; the second start is ignored; start_ready=0 until done.
- Reset mid-op:
  - Stimulus: assert rst_n low after the second row0 beat, then release and rerun basic.
  - Required: all outputs 0 and start_ready=1 during reset; rerun yields 1000 and 180.
- Defaults:
  - Stimulus: default params, noise_select=0, plaintext=5.
  - Required: row0 = 0, row1 = 80, one done pulse.
